// File: rtl/stage_3_execute.sv
// Execute stage: single-cycle ALU plus an iterative 32-step multiply/divide
// unit that owns the HI/LO registers and stalls the front end while working.
module stage_3_execute (
  input  logic        clock,
  input  logic        reset,
  input  logic        exec_valid,
  input  logic [4:0]  alu_op,
  input  logic [31:0] reg_data_1,
  input  logic [31:0] reg_data_2,
  input  logic [31:0] imm_ext,
  input  logic        alu_src,
  input  logic [4:0]  shamt,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic [31:0] mem_write_data,
  output logic        stall
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_r;
  logic [4:0]  count_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic [31:0] acc_hi_r;   // product high half / partial remainder
  logic [31:0] acc_lo_r;   // multiplier bits / dividend bits -> quotient
  logic [31:0] opb_r;      // multiplicand / divisor magnitude
  logic        is_div_r;
  logic        neg_lo_r;   // negate product or quotient at the end
  logic        neg_hi_r;   // negate remainder at the end

  logic [31:0] op_b_s;
  logic        is_muldiv_s;
  logic        signed_s;
  logic        start_s;
  logic [32:0] sum_s;
  logic [32:0] trial_s;
  logic [31:0] step_hi_s;
  logic [31:0] step_lo_s;
  logic [63:0] prod_s;
  logic [31:0] fin_hi_s;
  logic [31:0] fin_lo_s;

  // Magnitude of a value, treating it as two's complement only when signed.
  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

  // Single-cycle ALU; mul/div codes and unused codes yield zero.
  function automatic logic [31:0] alu_eval(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh,
                                           input logic [31:0] hi, input logic [31:0] lo);
    logic [31:0] r;
    case (op)
      5'd0:    r = a + b;
      5'd1:    r = a - b;
      5'd2:    r = a & b;
      5'd3:    r = a | b;
      5'd4:    r = a ^ b;
      5'd5:    r = ~(a | b);
      5'd6:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd7:    r = (a < b) ? 32'd1 : 32'd0;
      5'd8:    r = b << sh;
      5'd9:    r = b >> sh;
      5'd10:   r = $unsigned($signed(b) >>> sh);
      5'd11:   r = {b[15:0], 16'd0};
      5'd12:   r = hi;
      5'd13:   r = lo;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign op_b_s         = alu_src ? imm_ext : reg_data_2;
  assign is_muldiv_s    = (alu_op[4:2] == 3'b100);
  assign signed_s       = ~alu_op[0];
  assign start_s        = exec_valid & is_muldiv_s;
  assign alu_result     = alu_eval(alu_op, reg_data_1, op_b_s, shamt, hi_r, lo_r);
  assign zero           = (alu_result == 32'd0);
  assign mem_write_data = reg_data_2;
  assign stall          = reset & (((state_r == ST_IDLE) & start_s) | (state_r == ST_BUSY));

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    step_hi_s = acc_hi_r;
    step_lo_s = acc_lo_r;
    sum_s     = 33'd0;
    trial_s   = 33'd0;
    if (is_div_r) begin
      trial_s = {acc_hi_r, acc_lo_r[31]} - {1'b0, opb_r};
      if (!trial_s[32]) begin
        step_hi_s = trial_s[31:0];
        step_lo_s = {acc_lo_r[30:0], 1'b1};
      end else begin
        step_hi_s = {acc_hi_r[30:0], acc_lo_r[31]};
        step_lo_s = {acc_lo_r[30:0], 1'b0};
      end
    end else begin
      sum_s     = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opb_r} : 33'd0);
      step_hi_s = sum_s[32:1];
      step_lo_s = {sum_s[0], acc_lo_r[31:1]};
    end
  end

  // Sign fix applied to the result of the final iteration.
  always_comb begin
    prod_s   = {step_hi_s, step_lo_s};
    fin_hi_s = step_hi_s;
    fin_lo_s = step_lo_s;
    if (is_div_r) begin
      fin_lo_s = neg_lo_r ? (32'd0 - step_lo_s) : step_lo_s;
      fin_hi_s = neg_hi_r ? (32'd0 - step_hi_s) : step_hi_s;
    end else begin
      if (neg_lo_r) begin
        prod_s = 64'd0 - {step_hi_s, step_lo_s};
      end else begin
        prod_s = {step_hi_s, step_lo_s};
      end
      fin_hi_s = prod_s[63:32];
      fin_lo_s = prod_s[31:0];
    end
  end

  // Mul/div sequencer: accept in IDLE, iterate 32 times in BUSY, retire in DONE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      count_r  <= 5'd0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
      acc_hi_r <= 32'd0;
      acc_lo_r <= 32'd0;
      opb_r    <= 32'd0;
      is_div_r <= 1'b0;
      neg_lo_r <= 1'b0;
      neg_hi_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r  <= ST_BUSY;
            count_r  <= 5'd0;
            acc_hi_r <= 32'd0;
            acc_lo_r <= mag(reg_data_1, signed_s);
            opb_r    <= mag(op_b_s, signed_s);
            is_div_r <= alu_op[1];
            // A zero divisor keeps the all-ones quotient un-negated.
            neg_lo_r <= signed_s & (reg_data_1[31] ^ op_b_s[31]) & (op_b_s != 32'd0);
            neg_hi_r <= signed_s & reg_data_1[31] & alu_op[1];
          end
        end
        ST_BUSY: begin
          acc_hi_r <= step_hi_s;
          acc_lo_r <= step_lo_s;
          count_r  <= count_r + 5'd1;
          if (count_r == 5'd31) begin
            state_r <= ST_DONE;
            hi_r    <= fin_hi_s;
            lo_r    <= fin_lo_s;
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_3_execute.sv
// Self-checking bench for stage_3_execute with a high-level arithmetic model.
module tb_stage_3_execute;

  logic        clock = 1'b0;
  logic        reset;
  logic        exec_valid;
  logic [4:0]  alu_op;
  logic [31:0] reg_data_1;
  logic [31:0] reg_data_2;
  logic [31:0] imm_ext;
  logic        alu_src;
  logic [4:0]  shamt;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] mem_write_data;
  logic        stall;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  stage_3_execute dut (
    .clock(clock), .reset(reset), .exec_valid(exec_valid), .alu_op(alu_op),
    .reg_data_1(reg_data_1), .reg_data_2(reg_data_2), .imm_ext(imm_ext),
    .alu_src(alu_src), .shamt(shamt), .alu_result(alu_result), .zero(zero),
    .mem_write_data(mem_write_data), .stall(stall)
  );

  always #5 clock = ~clock;

  // Reference ALU from the operation table.
  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a ^ b;
      5'd5:  return ~(a | b);
      5'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd7:  return (a < b) ? 32'd1 : 32'd0;
      5'd8:  return b << sh;
      5'd9:  return b >> sh;
      5'd10: return $unsigned($signed(b) >>> sh);
      5'd11: return b * 32'd65536;
      5'd12: return m_hi;
      5'd13: return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  // Reference mul/div using 64-bit arithmetic.
  function automatic void model_muldiv(input logic [4:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    longint sa, sb, sp, sq, sr;
    logic [63:0] up;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      5'd16: begin sp = sa * sb; up = sp; m_hi = up[63:32]; m_lo = up[31:0]; end
      5'd17: begin up = {32'd0, a} * {32'd0, b}; m_hi = up[63:32]; m_lo = up[31:0]; end
      5'd18: begin
        if (b == 32'd0) begin m_lo = 32'hFFFFFFFF; m_hi = a; end
        else begin
          sq = sa / sb; sr = sa % sb;
          up = sq; m_lo = up[31:0];
          up = sr; m_hi = up[31:0];
        end
      end
      5'd19: begin
        if (b == 32'd0) begin m_lo = 32'hFFFFFFFF; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      default: begin m_hi = m_hi; end
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Issue a mul/div in C0 and count stall cycles until stall drops (bounded).
  task automatic run_muldiv(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                            input bit hold, output int n, output logic [31:0] c0_res);
    exec_valid = 1'b1; alu_op = op; reg_data_1 = a; reg_data_2 = b; alu_src = 1'b0;
    #2;
    c0_res = alu_result;
    n = 0;
    for (int i = 0; i < 100 && stall === 1'b1; i++) begin
      n++;
      next_cycle();
      if (!hold) exec_valid = 1'b0;
      #2;
    end
  endtask

  // Read HI then LO in the two cycles following the current one.
  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    next_cycle();
    exec_valid = 1'b0; alu_op = 5'd12; #2; hi = alu_result;
    next_cycle();
    alu_op = 5'd13; #2; lo = alu_result;
  endtask

  task automatic test_reset();
    reset = 1'b0; exec_valid = 1'b0; alu_op = 5'd12; reg_data_1 = 32'd0;
    reg_data_2 = 32'h1234_5678; imm_ext = 32'd0; alu_src = 1'b0; shamt = 5'd0;
    #12;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++;
    if (alu_result !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", alu_result); end
    alu_op = 5'd13; #1;
    checks++;
    if (alu_result !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", alu_result); end
    checks++;
    if (mem_write_data !== 32'h1234_5678) begin
      errors++; $display("FAIL reset_mwd got %h want 12345678", mem_write_data);
    end
    #5 reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_alu();
    logic [4:0]  t_op  [8] = '{5'd0, 5'd1, 5'd6, 5'd7, 5'd10, 5'd11, 5'd0, 5'd2};
    logic [31:0] t_a   [8] = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd10, 32'hF0F0F0F0};
    logic [31:0] t_b   [8] = '{32'd1, 32'd5, 32'd1, 32'd1, 32'h80000000, 32'd0, 32'd999, 32'hFF00FF00};
    logic [31:0] t_imm [8] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h1234, 32'd7, 32'd0};
    logic        t_src [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] t_exp [8] = '{32'h80000000, 32'd0, 32'd1, 32'd0, 32'hF8000000, 32'h12340000, 32'd17, 32'hF000F000};
    logic [31:0] exp_v;
    for (int i = 0; i < 8; i++) begin
      exec_valid = 1'b1; alu_op = t_op[i]; reg_data_1 = t_a[i]; reg_data_2 = t_b[i];
      imm_ext = t_imm[i]; alu_src = t_src[i]; shamt = 5'd4;
      #2;
      checks++;
      if (alu_result !== t_exp[i] || zero !== (t_exp[i] == 32'd0)) begin
        errors++;
        $display("FAIL alu_dir%0d got %h/%b want %h/%b", i, alu_result, zero, t_exp[i], t_exp[i] == 32'd0);
      end
      next_cycle();
    end
    for (int i = 0; i < 60; i++) begin
      alu_op = 5'($urandom_range(0, 27));
      if (alu_op >= 5'd16) alu_op = alu_op + 5'd4;
      reg_data_1 = $urandom; reg_data_2 = $urandom; imm_ext = $urandom;
      if (i % 7 == 0) reg_data_2 = reg_data_1;
      alu_src = 1'($urandom_range(0, 1)); shamt = 5'($urandom_range(0, 31));
      exec_valid = 1'b1;
      #2;
      exp_v = ref_alu(alu_op, reg_data_1, alu_src ? imm_ext : reg_data_2, shamt);
      checks++;
      if (alu_result !== exp_v || zero !== (exp_v == 32'd0) || mem_write_data !== reg_data_2 || stall !== 1'b0) begin
        errors++;
        $display("FAIL alu_rnd op%0d got %h/%b/%h/%b want %h/%b/%h/0", alu_op, alu_result, zero,
                 mem_write_data, stall, exp_v, exp_v == 32'd0, reg_data_2);
      end
      next_cycle();
    end
  endtask

  // Run one mul/div and compare stall length, C0 result and HI/LO.
  task automatic test_muldiv_case(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    logic [31:0] c0, hi, lo;
    run_muldiv(op, a, b, 1'b0, n, c0);
    model_muldiv(op, a, b);
    checks++;
    if (n != 33 || c0 !== 32'd0) begin
      errors++; $display("FAIL muldiv_stall op%0d got %0d cycles res %h want 33 cycles res 0", op, n, c0);
    end
    read_hilo(hi, lo);
    checks++;
    if (hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL muldiv_hilo op%0d a=%h b=%h got %h:%h want %h:%h", op, a, b, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_mul();
    test_muldiv_case(5'd16, 32'hFFFFFFFF, 32'd3);
    test_muldiv_case(5'd17, 32'hFFFFFFFF, 32'd3);
  endtask

  task automatic test_div();
    test_muldiv_case(5'd18, 32'hFFFFFFF9, 32'd2);
    test_muldiv_case(5'd19, 32'd100, 32'd7);
  endtask

  task automatic test_div_boundary();
    test_muldiv_case(5'd19, 32'd5, 32'd0);
    test_muldiv_case(5'd18, 32'h80000000, 32'hFFFFFFFF);
    test_muldiv_case(5'd18, 32'hFFFFFFF6, 32'd0);
  endtask

  task automatic test_random_muldiv();
    logic [31:0] a, b;
    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = $urandom;
      if (i == 2) b = 32'd0;
      if (i == 3) b = 32'($urandom_range(1, 20));
      test_muldiv_case(5'(16 + $urandom_range(0, 3)), a, b);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] c0, hi, lo;
    run_muldiv(5'd16, 32'd7, 32'd9, 1'b1, n, c0);
    model_muldiv(5'd16, 32'd7, 32'd9);
    checks++;
    if (n != 33) begin errors++; $display("FAIL b2b_first got %0d cycles want 33", n); end
    next_cycle();
    run_muldiv(5'd16, 32'hFFFFFFFE, 32'd5, 1'b0, n, c0);
    model_muldiv(5'd16, 32'hFFFFFFFE, 32'd5);
    checks++;
    if (n != 33) begin errors++; $display("FAIL b2b_second got %0d cycles want 33", n); end
    read_hilo(hi, lo);
    checks++;
    if (hi !== m_hi || lo !== m_lo) begin
      errors++; $display("FAIL b2b_hilo got %h:%h want %h:%h", hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [31:0] hi, lo;
    exec_valid = 1'b1; alu_op = 5'd16; reg_data_1 = 32'd12345; reg_data_2 = 32'd678; alu_src = 1'b0;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      exec_valid = 1'b0;
    end
    #2;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL midbusy_pre got %b want 1", stall); end
    reset = 1'b0;
    #1;
    m_hi = 32'd0; m_lo = 32'd0;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL midbusy_stall got %b want 0", stall); end
    next_cycle();
    #2 reset = 1'b1;
    read_hilo(hi, lo);
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL midbusy_hilo got %h:%h want 0:0", hi, lo);
    end
    next_cycle();
    test_muldiv_case(5'd19, 32'd9, 32'd3);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mul();
    test_div();
    test_div_boundary();
    test_random_muldiv();
    test_back_to_back();
    test_reset_mid_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
